// File: rtl/tb_wait_event_ctrl.sv
// tb_wait_event_ctrl: cycle-accurate, abortable wait on one of the testbench
// wait-event inputs. A command (alias, mode, mask/value, timeout) is latched
// on acceptance. The selected input is then watched until its condition
// holds or the evaluation budget runs out. Completion is reported with a
// one-cycle o_done pulse and the number of evaluations performed.
//
// Optional feature: define TB_WAIT_EVENT_CNT_EN to add the i_count port.
// With it, the wait completes only on the i_count-th true evaluation.
// In level mode those evaluations must be consecutive.
// Without it, the first true evaluation completes the wait.

module tb_wait_event_ctrl #(
    parameter int ALIAS_NB = 5,
    parameter int WIDTH    = 32,
    parameter int TO_WIDTH = 32,
    localparam int SEL_W   = (ALIAS_NB > 1) ? $clog2(ALIAS_NB) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_start,
    input  logic [SEL_W-1:0]              i_sel,
    input  logic [1:0]                    i_mode,
    input  logic [WIDTH-1:0]              i_mask,
    input  logic [WIDTH-1:0]              i_value,
    input  logic [TO_WIDTH-1:0]           i_timeout,
    input  logic                          i_abort,
`ifdef TB_WAIT_EVENT_CNT_EN
    input  logic [7:0]                    i_count,
`endif
    input  logic [ALIAS_NB-1:0][WIDTH-1:0] i_wait,
    output logic                          o_busy,
    output logic                          o_done,
    output logic                          o_timeout,
    output logic [TO_WIDTH-1:0]           o_elapsed
);

    localparam logic [1:0] MODE_RISE  = 2'b00;
    localparam logic [1:0] MODE_FALL  = 2'b01;
    localparam logic [1:0] MODE_ANY   = 2'b10;
    localparam logic [1:0] MODE_LEVEL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_nextState;

    // Latched command fields
    logic [SEL_W-1:0]      r_sel;
    logic [1:0]            r_mode;
    logic [WIDTH-1:0]      r_mask;
    logic [WIDTH-1:0]      r_value;
    logic [TO_WIDTH-1:0]   r_timeout;

    // Wait datapath
    logic [WIDTH-1:0]      r_prev;
    logic [TO_WIDTH-1:0]   r_elapsed;
    logic                  r_timedOut;

    logic                  w_accept;
    logic                  w_selValid;
    logic [WIDTH-1:0]      w_cur;
    logic                  w_condRaw;
    logic                  w_hit;
    logic                  w_toHit;
    logic [TO_WIDTH-1:0]   w_evalNum;
    logic                  w_evalArm;
    logic                  w_evalWait;

`ifdef TB_WAIT_EVENT_CNT_EN
    logic [7:0]            r_need;
    logic [7:0]            r_occur;
`endif

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_evalArm  = (r_state == S_ARM)  && !i_abort;
    assign w_evalWait = (r_state == S_WAIT) && !i_abort;
    assign w_evalNum  = r_elapsed + TO_WIDTH'(1);
    assign w_toHit    = (r_timeout != '0) && (w_evalNum == r_timeout);

    // Select the monitored alias; an out-of-range index reads as invalid
    always_comb begin
        w_selValid = 1'b0;
        w_cur      = '0;
        for (int i = 0; i < ALIAS_NB; i++) begin
            if (r_sel == SEL_W'(i)) begin
                w_selValid = 1'b1;
                w_cur      = i_wait[i];
            end
        end
    end

    // Raw wait condition from the current and previous samples
    always_comb begin
        w_condRaw = 1'b0;
        case (r_mode)
            MODE_RISE:  w_condRaw = !r_prev[0] && w_cur[0];
            MODE_FALL:  w_condRaw = r_prev[0] && !w_cur[0];
            MODE_ANY:   w_condRaw = r_prev[0] ^ w_cur[0];
            MODE_LEVEL: w_condRaw = ((w_cur ^ r_value) & r_mask) == '0;
            default:    w_condRaw = 1'b0;
        endcase
    end

`ifdef TB_WAIT_EVENT_CNT_EN
    // Completing occurrence: the true evaluation that reaches the required count
    always_comb begin
        w_hit = w_condRaw && (r_occur == (r_need - 8'd1));
    end

    // Occurrence counter; level mode only counts unbroken runs of true evaluations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_need  <= 8'd1;
            r_occur <= 8'd0;
        end else if (w_accept) begin
            r_need  <= (i_count == 8'd0) ? 8'd1 : i_count;
            r_occur <= 8'd0;
        end else if (w_evalWait) begin
            if (w_condRaw) begin
                r_occur <= r_occur + 8'd1;
            end else if (r_mode == MODE_LEVEL) begin
                r_occur <= 8'd0;
            end
        end
    end
`else
    // The first true evaluation completes the wait
    always_comb begin
        w_hit = w_condRaw;
    end
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; abort only matters while a wait is armed or running
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_nextState = S_ARM;
                end
            end
            S_ARM: begin
                if (i_abort) begin
                    w_nextState = S_IDLE;
                end else if (!w_selValid) begin
                    w_nextState = S_DONE;
                end else begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_abort) begin
                    w_nextState = S_IDLE;
                end else if (w_hit || w_toHit) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE: begin
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Latch the command fields on acceptance; a start while busy is ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel     <= '0;
            r_mode    <= MODE_RISE;
            r_mask    <= '0;
            r_value   <= '0;
            r_timeout <= '0;
        end else if (w_accept) begin
            r_sel     <= i_sel;
            r_mode    <= i_mode;
            r_mask    <= i_mask;
            r_value   <= i_value;
            r_timeout <= i_timeout;
        end
    end

    // Previous sample: captured in ARM so pre-existing levels never look like edges
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
        end else if (w_evalArm || w_evalWait) begin
            r_prev <= w_cur;
        end
    end

    // Elapsed count and timeout flag; a true condition beats a same-cycle timeout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_elapsed  <= '0;
            r_timedOut <= 1'b0;
        end else if (w_accept) begin
            r_elapsed  <= '0;
            r_timedOut <= 1'b0;
        end else if (w_evalArm) begin
            if (!w_selValid) begin
                r_timedOut <= 1'b1;
            end
        end else if (w_evalWait) begin
            if (r_elapsed != '1) begin
                r_elapsed <= w_evalNum;
            end
            if (!w_hit && w_toHit) begin
                r_timedOut <= 1'b1;
            end
        end
    end

    // Outputs decoded from the state and the held datapath registers
    always_comb begin
        o_busy    = (r_state != S_IDLE);
        o_done    = (r_state == S_DONE);
        o_timeout = (r_state == S_DONE) && r_timedOut;
        o_elapsed = r_elapsed;
    end

endmodule
